// File: rtl/serial_pattern_feeder.sv
// serial_pattern_feeder: buffers parallel words in a small FIFO and shifts
// them out one bit per clock on j, which feeds the 10110 detector's j input.
//   clk, rst         : single clock, synchronous active-high reset
//   din/din_valid    : parallel word offered upstream
//   din_ready        : FIFO has room (decoded from the registered count)
//   j/j_valid        : registered serial bit, and whether it carries data
//   word_done        : high while j carries the last bit of a word
//   fifo_count       : words buffered, not counting the word in the shifter
module serial_pattern_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic                     j,
  output logic                     j_valid,
  output logic                     word_done,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] sreg, sreg_nx;
  logic [CW-1:0]    bit_cnt, bit_cnt_nx;
  logic             j_nx, j_valid_nx, word_done_nx;
  logic             push, pop;
  logic [WIDTH-1:0] head;

  assign din_ready = (fifo_count < FULL_CNT);
  assign push      = din_valid & din_ready;
  assign head      = mem[rd_ptr];

  // sreg holds the bits still to be sent, aligned so the next bit is always
  // at the end selected by MSB_FIRST.
  always_comb begin
    state_nx     = state;
    sreg_nx      = sreg;
    bit_cnt_nx   = bit_cnt;
    j_nx         = IDLE_BIT;
    j_valid_nx   = 1'b0;
    word_done_nx = 1'b0;
    pop          = 1'b0;

    case (state)
      IDLE: begin
        if (fifo_count != '0) pop = 1'b1;
      end
      SHIFT: begin
        if (bit_cnt != LAST_CNT) begin
          j_nx         = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
          sreg_nx      = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
          bit_cnt_nx   = bit_cnt + CW'(1);
          j_valid_nx   = 1'b1;
          word_done_nx = (bit_cnt_nx == LAST_CNT);
        end else if (fifo_count != '0) begin
          pop = 1'b1;
        end else begin
          state_nx   = IDLE;
          bit_cnt_nx = '0;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Loading a new word sends its first bit on the same edge, so words
    // chain back-to-back without a gap cycle.
    if (pop) begin
      state_nx   = SHIFT;
      j_nx       = MSB_FIRST ? head[WIDTH-1] : head[0];
      sreg_nx    = MSB_FIRST ? {head[WIDTH-2:0], 1'b0} : {1'b0, head[WIDTH-1:1]};
      bit_cnt_nx = CW'(1);
      j_valid_nx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      sreg       <= '0;
      bit_cnt    <= '0;
      j          <= IDLE_BIT;
      j_valid    <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      state     <= state_nx;
      sreg      <= sreg_nx;
      bit_cnt   <= bit_cnt_nx;
      j         <= j_nx;
      j_valid   <= j_valid_nx;
      word_done <= word_done_nx;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= din;
  end

endmodule
